lsu_mem_ctrl: RTL and testbench

//  Load/store unit consuming decoded memory controls (load, store, op_PMEM, op_load_sext).

---
 rtl/lsu_mem_ctrl_if.sv | 40 ++++
 rtl/lsu_mem_ctrl.sv | 122 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Execute-side request and data-memory port bundle for the load/store unit.
// master = execute stage plus memory model, slave = the LSU itself.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              load;
  logic              store;
  logic [7:0]        op_PMEM;
  logic [1:0]        op_load_sext;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req_valid, load, store, op_PMEM, op_load_sext,
    output addr, wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_wen, mem_addr,
    input  mem_wdata, mem_wmask, rsp_valid, rdata, err
  );

  modport slave (
    input  req_valid, load, store, op_PMEM, op_load_sext,
    input  addr, wdata, mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_wen, mem_addr,
    output mem_wdata, mem_wmask, rsp_valid, rdata, err
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: aligns the access, drives one memory request,
// and returns extended load data with a single-cycle done pulse.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic           clk,
  input logic           rst,
  lsu_mem_ctrl_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        sext_q;
  logic [1:0]        off_q;
  logic              wen_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wmask_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              legal;
  logic              misal;
  logic              bad;
  logic              accept;
  logic              sgn;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] ext;

  always_comb begin
    size_d = SZ_B;
    legal  = 1'b1;
    case (bus.op_PMEM)
      8'h01:   size_d = SZ_B;
      8'h03:   size_d = SZ_H;
      8'h0f:   size_d = SZ_W;
      default: legal  = 1'b0;
    endcase
  end

  assign misal  = (size_d == SZ_H && bus.addr[0])
               || (size_d == SZ_W && bus.addr[1:0] != 2'b00);
  assign bad    = !legal || (bus.load && bus.store) || misal;
  assign accept = (state_q == S_IDLE) && bus.req_valid
               && (bus.load || bus.store);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = bad ? S_DONE : S_REQ;
      S_REQ:  if (bus.mem_req_ready) state_d = S_WAIT;
      S_WAIT: if (bus.mem_rsp_valid) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Extraction uses the latched offset, not the live address.
  always_comb begin
    sh  = bus.mem_rdata >> {off_q, 3'b000};
    sgn = (size_q == SZ_B && sext_q == 2'b01)
       || (size_q == SZ_H && sext_q == 2'b10);
    ext = sh;
    case (size_q)
      SZ_B: ext = {{(DATA_W-8){sgn & sh[7]}}, sh[7:0]};
      SZ_H: ext = {{(DATA_W-16){sgn & sh[15]}}, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      size_q  <= SZ_B;
      sext_q  <= '0;
      off_q   <= '0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= size_d;
        sext_q  <= bus.op_load_sext;
        off_q   <= bus.addr[1:0];
        wen_q   <= bus.store;
        addr_q  <= {bus.addr[ADDR_W-1:2], 2'b00};
        wdata_q <= bus.wdata << {bus.addr[1:0], 3'b000};
        wmask_q <= bus.store ? (bus.op_PMEM[3:0] << bus.addr[1:0])
                             : 4'b0000;
        err_q   <= bad;
        if (bad) rdata_q <= '0;
      end
      if (state_q == S_WAIT && bus.mem_rsp_valid)
        rdata_q <= wen_q ? '0 : ext;
    end
  end

  assign bus.req_ready     = (state_q == S_IDLE);
  assign bus.mem_req_valid = (state_q == S_REQ);
  assign bus.mem_wen       = wen_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.rsp_valid     = (state_q == S_DONE);
  assign bus.rdata         = rdata_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl against an arithmetic access model,
// with a reactive memory responder and directed corner scenarios.
module tb_lsu_mem_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_pass = 0;
  int n_total = 0;

  lsu_mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void model(
    input  bit          ld,
    input  bit          st,
    input  logic [7:0]  op,
    input  logic [1:0]  sx,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] mw,
    output bit          e,
    output logic [31:0] ea,
    output logic [31:0] ewd,
    output logic [3:0]  em,
    output logic [31:0] erd
  );
    int n, off, bits;
    logic [31:0] word, lo, val;
    bit sg;
    case (op)
      8'h01:   n = 1;
      8'h03:   n = 2;
      8'h0f:   n = 4;
      default: n = 0;
    endcase
    off = int'(a % 4);
    e   = (n == 0) || (ld && st) || ((n != 0) && (off % n != 0));
    ea  = a - off;
    ewd = wd << (8 * off);
    em  = st ? 4'(((1 << n) - 1) << off) : 4'b0;
    erd = 32'h0;
    if (!e && !st) begin
      word = mw >> (8 * off);
      bits = 8 * n;
      if (n == 4) begin
        val = word;
      end else begin
        lo  = (32'd1 << bits) - 32'd1;
        val = word & lo;
        sg  = (n == 1 && sx == 2'b01) || (n == 2 && sx == 2'b10);
        if (sg && ((val >> (bits - 1)) & 32'd1) == 32'd1) val = val | ~lo;
      end
      erd = val;
    end
  endfunction

  task automatic run_txn(
    input  string       nm,
    input  bit          ld,
    input  bit          st,
    input  logic [7:0]  op,
    input  logic [1:0]  sx,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] mw,
    input  int          rd,
    input  int          sd,
    input  bit          noise,
    output logic [31:0] got_rd,
    output logic        got_err
  );
    bit e;
    logic [31:0] ea, ewd, erd, held;
    logic [3:0] em;
    int nv, hs_k, rsp_k, n_rsp, exp_lat;
    bit stable_bad, busy_bad, hold_bad;
    model(ld, st, op, sx, a, wd, mw, e, ea, ewd, em, erd);
    nv = 0; hs_k = 0; rsp_k = 0; n_rsp = 0;
    stable_bad = 0; busy_bad = 0; hold_bad = 0;
    got_rd = 'x; got_err = 1'bx; held = 'x;
    @(negedge clk);
    n_total++;
    if (bus.req_ready !== 1'b1)
      $display("FAIL %s req_ready_idle got=%b exp=1", nm, bus.req_ready);
    else n_pass++;
    bus.req_valid = 1'b1; bus.load = ld; bus.store = st;
    bus.op_PMEM = op; bus.op_load_sext = sx; bus.addr = a; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.load = 1'b0; bus.store = 1'b0;
    bus.addr = $urandom; bus.wdata = $urandom;
    bus.op_PMEM = 8'($urandom); bus.op_load_sext = 2'($urandom);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        n_rsp++;
        if (n_rsp == 1) begin
          rsp_k = k; got_rd = bus.rdata; got_err = bus.err;
        end
      end
      if (n_rsp > 0 && k == rsp_k + 1) begin
        held = bus.rdata;
        if (held !== got_rd) hold_bad = 1;
      end
      if ((n_rsp == 0 || k == rsp_k) && bus.req_ready !== 1'b0) busy_bad = 1;
      if (bus.mem_req_valid === 1'b1) begin
        nv++;
        if (bus.mem_addr !== ea || bus.mem_wmask !== em
            || bus.mem_wen !== st || (st && bus.mem_wdata !== ewd))
          stable_bad = 1;
        if (nv > rd) begin
          bus.mem_req_ready = 1'b1;
          hs_k = k;
        end else if (noise) begin
          bus.mem_rsp_valid = 1'b1;
          bus.mem_rdata = $urandom;
        end
      end
      if (hs_k > 0 && k == hs_k + 1 + sd) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rdata = mw;
      end
      if (n_rsp > 0 && k >= rsp_k + 2) break;
    end
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    exp_lat = e ? 1 : 3 + rd + sd;
    n_total++;
    if (n_rsp != 1) $display("FAIL %s rsp_count got=%0d exp=1", nm, n_rsp);
    else n_pass++;
    n_total++;
    if (rsp_k != exp_lat) $display("FAIL %s latency got=%0d exp=%0d", nm, rsp_k, exp_lat);
    else n_pass++;
    n_total++;
    if (got_err !== e) $display("FAIL %s err got=%b exp=%b", nm, got_err, e);
    else n_pass++;
    n_total++;
    if (got_rd !== erd) $display("FAIL %s rdata got=%h exp=%h", nm, got_rd, erd);
    else n_pass++;
    n_total++;
    if (nv != (e ? 0 : rd + 1))
      $display("FAIL %s mem_req_cycles got=%0d exp=%0d", nm, nv, e ? 0 : rd + 1);
    else n_pass++;
    n_total++;
    if (stable_bad)
      $display("FAIL %s mem_fields got=%h/%b/%h exp=%h/%b/%h", nm,
               bus.mem_addr, bus.mem_wmask, bus.mem_wdata, ea, em, ewd);
    else n_pass++;
    n_total++;
    if (busy_bad) $display("FAIL %s req_ready_busy got=1 exp=0", nm);
    else n_pass++;
    n_total++;
    if (hold_bad) $display("FAIL %s rdata_hold got=%h exp=%h", nm, held, got_rd);
    else n_pass++;
  endtask

  task automatic test_reset;
    bus.req_valid = 0; bus.load = 0; bus.store = 0; bus.op_PMEM = 0;
    bus.op_load_sext = 0; bus.addr = 0; bus.wdata = 0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_total++;
    if ({bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.err, bus.mem_wen} !== 5'b10000)
      $display("FAIL reset_ctrl got=%b exp=10000",
               {bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.err, bus.mem_wen});
    else n_pass++;
    n_total++;
    if (bus.rdata !== 0 || bus.mem_addr !== 0 || bus.mem_wdata !== 0 || bus.mem_wmask !== 0)
      $display("FAIL reset_data got=%h/%h/%h/%b exp=0", bus.rdata, bus.mem_addr,
               bus.mem_wdata, bus.mem_wmask);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] r;
    logic e;
    run_txn("lb_sext", 1, 0, 8'h01, 2'b01, 32'h8000_0003, 0, 32'h8012_3456, 0, 0, 0, r, e);
    n_total++;
    if (r !== 32'hFFFF_FF80) $display("FAIL lb_const got=%h exp=ffffff80", r);
    else n_pass++;
    run_txn("lhu", 1, 0, 8'h03, 2'b00, 32'h8000_0002, 0, 32'hBEEF_1234, 0, 0, 0, r, e);
    n_total++;
    if (r !== 32'h0000_BEEF || e !== 1'b0)
      $display("FAIL lhu_const got=%h/%b exp=0000beef/0", r, e);
    else n_pass++;
    run_txn("sh", 0, 1, 8'h03, 2'b00, 32'h8000_0006, 32'h0000_1234, $urandom, 0, 0, 0, r, e);
    run_txn("lw_misal", 1, 0, 8'h0f, 2'b00, 32'h8000_0001, 0, $urandom, 0, 0, 0, r, e);
    n_total++;
    if (e !== 1'b1) $display("FAIL lw_misal_const got=%b exp=1", e);
    else n_pass++;
    run_txn("stall3", 1, 0, 8'h0f, 2'b00, 32'h0000_0100, 0, 32'hCAFE_F00D, 3, 1, 1, r, e);
    run_txn("lb_zext_sext11", 1, 0, 8'h01, 2'b11, 32'h0000_0001, 0, 32'h0000_F000, 0, 0, 0, r, e);
    run_txn("both_ld_st", 1, 1, 8'h01, 2'b00, 32'h0000_0000, 0, 0, 0, 0, 0, r, e);
    run_txn("illegal_op", 0, 1, 8'h07, 2'b00, 32'h0000_0000, 1, 0, 0, 0, 0, r, e);
  endtask

  task automatic test_idle_noise;
    int n_rsp = 0;
    bit rdy_bad = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.load = 1'b0; bus.store = 1'b0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rdata = $urandom;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_rsp++;
      if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0) rdy_bad = 1;
    end
    bus.req_valid = 1'b0; bus.mem_rsp_valid = 1'b0;
    n_total++;
    if (n_rsp != 0) $display("FAIL idle_no_pulse got=%0d exp=0", n_rsp);
    else n_pass++;
    n_total++;
    if (rdy_bad) $display("FAIL idle_stays got=busy exp=idle");
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    int n_rsp = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.load = 1'b1; bus.store = 1'b0;
    bus.op_PMEM = 8'h0f; bus.op_load_sext = 2'b00; bus.addr = 32'h0000_0200;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0; bus.load = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.mem_req_valid !== 1'b1) $display("FAIL mid_req got=%b exp=1", bus.mem_req_valid);
    else n_pass++;
    bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_total++;
    if (bus.req_ready !== 1'b1 || bus.mem_req_valid !== 1'b0)
      $display("FAIL mid_async got=%b%b exp=10", bus.req_ready, bus.mem_req_valid);
    else n_pass++;
    #1 rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) n_rsp++;
      bus.mem_rsp_valid = (k < 2);
      bus.mem_rdata = $urandom;
    end
    bus.mem_rsp_valid = 1'b0;
    n_total++;
    if (n_rsp != 0) $display("FAIL mid_no_rsp got=%0d exp=0", n_rsp);
    else n_pass++;
    n_total++;
    if (bus.req_ready !== 1'b1) $display("FAIL mid_idle got=%b exp=1", bus.req_ready);
    else n_pass++;
  endtask

  task automatic test_random;
    logic [31:0] r, a;
    logic e;
    logic [7:0] op;
    int p, q;
    bit ld, st;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 9);
      op = (p < 3) ? 8'h01 : (p < 6) ? 8'h03 : (p < 9) ? 8'h0f : 8'($urandom);
      if (p == 9 && (op == 8'h01 || op == 8'h03 || op == 8'h0f)) op = 8'h07;
      a = $urandom;
      if ($urandom_range(0, 3) != 0)
        a = (op == 8'h03) ? (a & ~32'd1) : (op == 8'h0f) ? (a & ~32'd3) : a;
      q = $urandom_range(0, 9);
      ld = (q <= 5); st = (q == 0) || (q > 5);
      run_txn("rand", ld, st, op, 2'($urandom), a, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom), r, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_idle_noise();
    test_reset_mid();
    test_random();
    test_directed();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
